// File: rtl/disp2isq_serializer_if.sv
// Handshake bundle between the 2-wide dispatch stage, the serializer and the
// 1-read/1-write issue queue. The serializer connects through the slave
// modport; the driving environment (dispatch + issue queue side) uses master.
interface disp2isq_serializer_if #(
  parameter int DATA_WIDTH      = 248,
  parameter int CONDITION_WIDTH = 2,
  parameter int ROBID_WIDTH     = 7
);

  // Dispatch side: up to two renamed instructions per cycle, lane 0 is older.
  logic                       disp_instr0_valid;
  logic [DATA_WIDTH-1:0]      disp_instr0_data;
  logic [CONDITION_WIDTH-1:0] disp_instr0_condition;
  logic                       disp_instr1_valid;
  logic [DATA_WIDTH-1:0]      disp_instr1_data;
  logic [CONDITION_WIDTH-1:0] disp_instr1_condition;
  logic                       disp_ready;

  // Issue queue enqueue handshake, one instruction per cycle.
  logic                       enqueue_valid;
  logic                       enqueue_ready;
  logic [DATA_WIDTH-1:0]      enqueue_data;
  logic [CONDITION_WIDTH-1:0] enqueue_condition;

  // Wakeup broadcast.
  logic                       update_condition_valid;
  logic [CONDITION_WIDTH-1:0] update_condition_mask;
  logic [ROBID_WIDTH-1:0]     update_condition_robid;
  logic [CONDITION_WIDTH-1:0] update_condition_data;

  // Pipeline flush and status.
  logic                       flush_valid;
  logic [1:0]                 occupancy;

  modport master (
    output disp_instr0_valid, disp_instr0_data, disp_instr0_condition,
    output disp_instr1_valid, disp_instr1_data, disp_instr1_condition,
    input  disp_ready,
    input  enqueue_valid, enqueue_data, enqueue_condition,
    output enqueue_ready,
    output update_condition_valid, update_condition_mask,
    output update_condition_robid, update_condition_data,
    output flush_valid,
    input  occupancy
  );

  modport slave (
    input  disp_instr0_valid, disp_instr0_data, disp_instr0_condition,
    input  disp_instr1_valid, disp_instr1_data, disp_instr1_condition,
    output disp_ready,
    output enqueue_valid, enqueue_data, enqueue_condition,
    input  enqueue_ready,
    input  update_condition_valid, update_condition_mask,
    input  update_condition_robid, update_condition_data,
    input  flush_valid,
    output occupancy
  );

endinterface

// File: rtl/disp2isq_serializer.sv
// Dispatch-to-issue-queue serializer. Buffers up to two renamed instructions
// in a 2-slot ring (head slot is the older one) and hands them to the issue
// queue one per cycle in program order. Wakeup broadcasts keep buffered
// conditions current; a flush empties the ring.
module disp2isq_serializer #(
  parameter int DATA_WIDTH      = 248,
  parameter int CONDITION_WIDTH = 2,
  parameter int ROBID_WIDTH     = 7
) (
  input logic                  clock,
  input logic                  reset_n,
  disp2isq_serializer_if.slave bus
);

  // Ring storage and head pointer.
  logic [1:0]                 slot_valid_q, slot_valid_d;
  logic [DATA_WIDTH-1:0]      slot_data_q [2];
  logic [DATA_WIDTH-1:0]      slot_data_d [2];
  logic [CONDITION_WIDTH-1:0] slot_cond_q [2];
  logic [CONDITION_WIDTH-1:0] slot_cond_d [2];
  logic                       head_q, head_d;

  // Handshake decode.
  logic [1:0]                 occupancy_w;
  logic                       enqueue_valid_w;
  logic                       enqueue_fire;
  logic                       disp_ready_w;
  logic                       accept;
  logic                       lane1_accept;

  // Applies a same-cycle wakeup broadcast to one condition vector when the
  // payload's robid field matches the broadcast target.
  function automatic logic [CONDITION_WIDTH-1:0] wake(
    input logic [DATA_WIDTH-1:0]      payload,
    input logic [CONDITION_WIDTH-1:0] cond,
    input logic                       upd_valid,
    input logic [ROBID_WIDTH-1:0]     upd_robid,
    input logic [CONDITION_WIDTH-1:0] upd_mask,
    input logic [CONDITION_WIDTH-1:0] upd_data
  );
    if (upd_valid && (payload[DATA_WIDTH-1 -: ROBID_WIDTH] == upd_robid))
      return (cond & ~upd_mask) | (upd_data & upd_mask);
    else
      return cond;
  endfunction

  assign occupancy_w = {1'b0, slot_valid_q[0]} + {1'b0, slot_valid_q[1]};

  // Handshake decode: a pair is only taken when the ring will be empty after
  // this cycle's fire, which keeps lane 0 always landing on the new head.
  always_comb begin
    enqueue_valid_w = slot_valid_q[head_q] && !bus.flush_valid;
    enqueue_fire    = enqueue_valid_w && bus.enqueue_ready;
    disp_ready_w    = !bus.flush_valid &&
                      ((occupancy_w == 2'd0) ||
                       ((occupancy_w == 2'd1) && enqueue_fire));
    accept          = disp_ready_w && bus.disp_instr0_valid;
    lane1_accept    = accept && bus.disp_instr1_valid;
  end

  assign bus.enqueue_valid     = enqueue_valid_w;
  assign bus.disp_ready        = disp_ready_w;
  assign bus.occupancy         = occupancy_w;
  assign bus.enqueue_data      = slot_data_q[head_q];
  assign bus.enqueue_condition = wake(slot_data_q[head_q], slot_cond_q[head_q],
                                      bus.update_condition_valid,
                                      bus.update_condition_robid,
                                      bus.update_condition_mask,
                                      bus.update_condition_data);

  // Next-state: flush wins outright; otherwise retire the head on fire, wake
  // surviving entries, then place accepted lanes starting at the new head.
  always_comb begin
    slot_valid_d = slot_valid_q;
    head_d       = head_q;
    for (int i = 0; i < 2; i++) begin
      slot_data_d[i] = slot_data_q[i];
      slot_cond_d[i] = slot_cond_q[i];
    end

    if (bus.flush_valid) begin
      slot_valid_d = 2'b00;
      head_d       = 1'b0;
    end else begin
      if (enqueue_fire) begin
        slot_valid_d[head_q] = 1'b0;
        head_d               = ~head_q;
      end

      for (int i = 0; i < 2; i++) begin
        if (slot_valid_d[i])
          slot_cond_d[i] = wake(slot_data_q[i], slot_cond_q[i],
                                bus.update_condition_valid,
                                bus.update_condition_robid,
                                bus.update_condition_mask,
                                bus.update_condition_data);
      end

      if (accept) begin
        slot_valid_d[head_d] = 1'b1;
        slot_data_d[head_d]  = bus.disp_instr0_data;
        slot_cond_d[head_d]  = wake(bus.disp_instr0_data,
                                    bus.disp_instr0_condition,
                                    bus.update_condition_valid,
                                    bus.update_condition_robid,
                                    bus.update_condition_mask,
                                    bus.update_condition_data);
      end

      if (lane1_accept) begin
        slot_valid_d[~head_d] = 1'b1;
        slot_data_d[~head_d]  = bus.disp_instr1_data;
        slot_cond_d[~head_d]  = wake(bus.disp_instr1_data,
                                     bus.disp_instr1_condition,
                                     bus.update_condition_valid,
                                     bus.update_condition_robid,
                                     bus.update_condition_mask,
                                     bus.update_condition_data);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_q <= 2'b00;
      head_q       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        slot_data_q[i] <= '0;
        slot_cond_q[i] <= '0;
      end
    end else begin
      slot_valid_q <= slot_valid_d;
      head_q       <= head_d;
      for (int i = 0; i < 2; i++) begin
        slot_data_q[i] <= slot_data_d[i];
        slot_cond_q[i] <= slot_cond_d[i];
      end
    end
  end

endmodule

// File: tb/tb_disp2isq_serializer.sv
// Bench for disp2isq_serializer: directed scenarios followed by random
// traffic, all checked against a program-order queue model.
module tb_disp2isq_serializer;

  localparam int DW = 248;
  localparam int CW = 2;
  localparam int RW = 7;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] cond;
  } entry_t;

  logic   clock   = 1'b0;
  logic   reset_n = 1'b0;
  entry_t model_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  logic [DW-1:0] p_a, p_b, p_c;

  always #5 clock = ~clock;

  disp2isq_serializer_if #(.DATA_WIDTH(DW), .CONDITION_WIDTH(CW), .ROBID_WIDTH(RW)) bus ();

  disp2isq_serializer #(.DATA_WIDTH(DW), .CONDITION_WIDTH(CW), .ROBID_WIDTH(RW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // One comparison point.
  task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] make_payload(input logic [RW-1:0] robid);
    logic [DW-1:0] p;
    for (int i = 0; i < 7; i++) p[i*32 +: 32] = $urandom;
    p[DW-1:224] = 24'($urandom);
    p[DW-1 -: RW] = robid;
    return p;
  endfunction

  // Condition an entry would hold after this cycle's broadcast.
  function automatic logic [CW-1:0] woken(input logic [DW-1:0] data, input logic [CW-1:0] cond);
    if (bus.update_condition_valid && data[DW-1 -: RW] == bus.update_condition_robid)
      return (cond & ~bus.update_condition_mask) | (bus.update_condition_data & bus.update_condition_mask);
    return cond;
  endfunction

  task automatic apply_stimulus(input logic v0, input logic [DW-1:0] d0, input logic [CW-1:0] c0,
                                input logic v1, input logic [DW-1:0] d1, input logic [CW-1:0] c1,
                                input logic rdy, input logic upd_v, input logic [RW-1:0] upd_r,
                                input logic [CW-1:0] upd_m, input logic [CW-1:0] upd_d,
                                input logic flush);
    bus.disp_instr0_valid      = v0;
    bus.disp_instr0_data       = d0;
    bus.disp_instr0_condition  = c0;
    bus.disp_instr1_valid      = v1;
    bus.disp_instr1_data       = d1;
    bus.disp_instr1_condition  = c1;
    bus.enqueue_ready          = rdy;
    bus.update_condition_valid = upd_v;
    bus.update_condition_robid = upd_r;
    bus.update_condition_mask  = upd_m;
    bus.update_condition_data  = upd_d;
    bus.flush_valid            = flush;
  endtask

  task automatic idle(input logic rdy);
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, rdy, 1'b0, '0, '0, '0, 1'b0);
  endtask

  // Check outputs against the model mid-cycle, then advance the model and
  // the DUT by one clock.
  task automatic cycle();
    logic exp_valid, exp_fire, exp_ready;
    entry_t e;
    @(negedge clock);
    #1;
    exp_valid = (model_q.size() != 0) && !bus.flush_valid;
    exp_fire  = exp_valid && bus.enqueue_ready;
    exp_ready = !bus.flush_valid && ((model_q.size() - int'(exp_fire)) == 0);
    check_output("enqueue_valid", DW'(bus.enqueue_valid), DW'(exp_valid));
    check_output("occupancy", DW'(bus.occupancy), DW'(model_q.size()));
    check_output("disp_ready", DW'(bus.disp_ready), DW'(exp_ready));
    if (exp_valid) begin
      check_output("enqueue_data", bus.enqueue_data, model_q[0].data);
      check_output("enqueue_condition", DW'(bus.enqueue_condition),
                   DW'(woken(model_q[0].data, model_q[0].cond)));
    end
    if (bus.flush_valid) begin
      model_q.delete();
    end else begin
      if (exp_fire) void'(model_q.pop_front());
      foreach (model_q[i]) model_q[i].cond = woken(model_q[i].data, model_q[i].cond);
      if (exp_ready && bus.disp_instr0_valid) begin
        e.data = bus.disp_instr0_data;
        e.cond = woken(bus.disp_instr0_data, bus.disp_instr0_condition);
        model_q.push_back(e);
        if (bus.disp_instr1_valid) begin
          e.data = bus.disp_instr1_data;
          e.cond = woken(bus.disp_instr1_data, bus.disp_instr1_condition);
          model_q.push_back(e);
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle(1'b0);

    // Reset state, before any clock edge.
    #3;
    check_output("reset_enqueue_valid", DW'(bus.enqueue_valid), DW'(1'b0));
    check_output("reset_occupancy", DW'(bus.occupancy), DW'(2'd0));
    check_output("reset_disp_ready", DW'(bus.disp_ready), DW'(1'b1));
    #10 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Pair 0x05/0x06 with the issue queue ready.
    $display("[TB] pair in order");
    p_a = make_payload(7'h05);
    p_b = make_payload(7'h06);
    apply_stimulus(1'b1, p_a, 2'b00, 1'b1, p_b, 2'b11, 1'b1, 1'b0, '0, '0, '0, 1'b0);
    cycle();
    idle(1'b1);
    #1;
    check_output("t1_first_robid", DW'(bus.enqueue_data[DW-1 -: RW]), DW'(7'h05));
    check_output("t1_ready_low", DW'(bus.disp_ready), DW'(1'b0));
    cycle();
    check_output("t1_second_robid", DW'(bus.enqueue_data[DW-1 -: RW]), DW'(7'h06));
    check_output("t1_ready_high", DW'(bus.disp_ready), DW'(1'b1));
    cycle();
    cycle();

    // Backpressure holds a full buffer.
    $display("[TB] backpressure");
    p_a = make_payload(7'h30);
    p_b = make_payload(7'h31);
    apply_stimulus(1'b1, p_a, 2'b01, 1'b1, p_b, 2'b10, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    cycle();
    idle(1'b0);
    #1;
    check_output("t2_occupancy_full", DW'(bus.occupancy), DW'(2'd2));
    check_output("t2_ready_low", DW'(bus.disp_ready), DW'(1'b0));
    cycle();
    cycle();
    check_output("t2_data_held", bus.enqueue_data, p_a);
    idle(1'b1);
    cycle();
    cycle();
    cycle();

    // Fire and pair accept in the same cycle across the head wrap.
    $display("[TB] fire plus accept");
    p_c = make_payload(7'h10);
    apply_stimulus(1'b1, p_c, 2'b00, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    cycle();
    p_a = make_payload(7'h11);
    p_b = make_payload(7'h12);
    apply_stimulus(1'b1, p_a, 2'b00, 1'b1, p_b, 2'b01, 1'b1, 1'b0, '0, '0, '0, 1'b0);
    #1;
    check_output("t3_ready_on_fire", DW'(bus.disp_ready), DW'(1'b1));
    cycle();
    idle(1'b0);
    #1;
    check_output("t3_occupancy", DW'(bus.occupancy), DW'(2'd2));
    check_output("t3_head_robid", DW'(bus.enqueue_data[DW-1 -: RW]), DW'(7'h11));
    idle(1'b1);
    cycle();
    check_output("t3_second_data", bus.enqueue_data, p_b);
    cycle();
    cycle();

    // Wakeup of a buffered entry, then a wakeup in the fire cycle.
    $display("[TB] wakeup");
    p_a = make_payload(7'h20);
    apply_stimulus(1'b1, p_a, 2'b00, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    cycle();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 7'h20, 2'b01, 2'b01, 1'b0);
    cycle();
    idle(1'b0);
    #1;
    check_output("t4_stored_wakeup", DW'(bus.enqueue_condition), DW'(2'b01));
    idle(1'b1);
    cycle();
    apply_stimulus(1'b1, p_a, 2'b00, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    cycle();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 7'h20, 2'b01, 2'b01, 1'b0);
    #1;
    check_output("t4_bypass_wakeup", DW'(bus.enqueue_condition), DW'(2'b01));
    cycle();
    p_b = make_payload(7'h21);
    apply_stimulus(1'b1, p_b, 2'b00, 1'b0, '0, '0, 1'b0, 1'b1, 7'h21, 2'b10, 2'b10, 1'b0);
    cycle();
    idle(1'b0);
    #1;
    check_output("t4_incoming_wakeup", DW'(bus.enqueue_condition), DW'(2'b10));
    idle(1'b1);
    cycle();

    // Flush with a full buffer and the issue queue ready.
    $display("[TB] flush");
    p_a = make_payload(7'h40);
    p_b = make_payload(7'h41);
    apply_stimulus(1'b1, p_a, 2'b00, 1'b1, p_b, 2'b00, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    cycle();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0, '0, 1'b1);
    #1;
    check_output("t5_no_fire", DW'(bus.enqueue_valid), DW'(1'b0));
    cycle();
    idle(1'b1);
    #1;
    check_output("t5_empty", DW'(bus.occupancy), DW'(2'd0));
    check_output("t5_ready", DW'(bus.disp_ready), DW'(1'b1));
    cycle();

    // Asynchronous reset in the middle of a drain.
    $display("[TB] async reset");
    p_a = make_payload(7'h50);
    p_b = make_payload(7'h51);
    apply_stimulus(1'b1, p_a, 2'b00, 1'b1, p_b, 2'b00, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    cycle();
    idle(1'b1);
    cycle();
    #2 reset_n = 1'b0;
    #1;
    check_output("t6_valid_async", DW'(bus.enqueue_valid), DW'(1'b0));
    check_output("t6_occupancy_async", DW'(bus.occupancy), DW'(2'd0));
    model_q.delete();
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;
    cycle();

    // Random traffic against the model.
    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      logic v0, v1;
      v0 = ($urandom_range(0, 3) != 0);
      v1 = v0 && $urandom_range(0, 1) == 1;
      apply_stimulus(v0, make_payload(RW'($urandom_range(0, 7))), CW'($urandom),
                     v1, make_payload(RW'($urandom_range(0, 7))), CW'($urandom),
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 2) == 0, RW'($urandom_range(0, 7)),
                     CW'($urandom), CW'($urandom),
                     $urandom_range(0, 19) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
